// File: rtl/static_pop_sched.sv
// Pop scheduler for the multi-FIFO static circular buffer: shadows occupancy from
// snooped pushes, pops round-robin, and streams returned data out under credit control.
module static_pop_sched #(
  parameter int NUMELEM  = 4,
  parameter int BITDATA  = 4,
  parameter int NUMFIFO  = 8,
  parameter int RDLAT    = 1,
  parameter int OUTDEPTH = 4,
  parameter int BITFIFO  = $clog2(NUMFIFO),
  parameter int BITELEM  = $clog2(NUMELEM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               buf_ready,
  input  logic               push,
  input  logic [BITFIFO-1:0] pu_prt,
  output logic               pop,
  output logic [BITFIFO-1:0] po_prt,
  input  logic [BITDATA-1:0] po_dout,
  output logic               out_vld,
  input  logic               out_ready,
  output logic [BITFIFO-1:0] out_prt,
  output logic [BITDATA-1:0] out_data,
  output logic               err
);

  localparam int BITCNT  = BITELEM + 1;
  localparam int BITCRD  = $clog2(OUTDEPTH + 1);
  localparam int BITOPTR = (OUTDEPTH > 1) ? $clog2(OUTDEPTH) : 1;

  logic [BITCNT-1:0]  cnt [NUMFIFO];
  logic [BITFIFO-1:0] rr_ptr;
  logic [BITFIFO-1:0] po_prt_q;
  logic [BITFIFO-1:0] sel_prt;
  logic [BITFIFO-1:0] cand;
  logic               any_elig;
  logic [BITCRD-1:0]  credit;
  logic [RDLAT-1:0]   tag_vld;
  logic [BITFIFO-1:0] tag_prt [RDLAT];
  logic [BITFIFO-1:0] fifo_prt [OUTDEPTH];
  logic [BITDATA-1:0] fifo_data [OUTDEPTH];
  logic [BITOPTR-1:0] wr_ptr;
  logic [BITOPTR-1:0] rd_ptr;
  logic [BITCRD-1:0]  occ;
  logic               fifo_wr;
  logic               out_hs;

  function automatic logic [BITOPTR-1:0] ptr_next(input logic [BITOPTR-1:0] p);
    return (p == BITOPTR'(OUTDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Descending scan so the last hit is the first eligible FIFO after rr_ptr.
  always_comb begin
    any_elig = 1'b0;
    sel_prt  = rr_ptr;
    cand     = '0;
    for (int i = NUMFIFO; i >= 1; i--) begin
      cand = BITFIFO'((int'(rr_ptr) + i) % NUMFIFO);
      if (cnt[cand] != '0) begin
        any_elig = 1'b1;
        sel_prt  = cand;
      end
    end
  end

  assign pop     = buf_ready && any_elig && (credit < BITCRD'(OUTDEPTH));
  assign po_prt  = pop ? sel_prt : po_prt_q;
  assign out_vld = (occ != '0);
  assign out_hs  = out_vld && out_ready;
  assign out_prt = fifo_prt[rd_ptr];
  assign out_data = fifo_data[rd_ptr];
  assign fifo_wr = tag_vld[RDLAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < NUMFIFO; f++) cnt[f] <= '0;
      err <= 1'b0;
    end else begin
      for (int f = 0; f < NUMFIFO; f++) begin
        if (push && pu_prt == BITFIFO'(f) && !(pop && po_prt == BITFIFO'(f))) begin
          if (cnt[f] != BITCNT'(NUMELEM)) cnt[f] <= cnt[f] + 1'b1;
          else                            err    <= 1'b1;
        end else if (pop && po_prt == BITFIFO'(f) && !(push && pu_prt == BITFIFO'(f))) begin
          cnt[f] <= cnt[f] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= BITFIFO'(NUMFIFO - 1);
      po_prt_q <= '0;
      credit   <= '0;
    end else begin
      if (pop) begin
        rr_ptr   <= sel_prt;
        po_prt_q <= sel_prt;
      end
      if (pop && !out_hs)      credit <= credit + 1'b1;
      else if (out_hs && !pop) credit <= credit - 1'b1;
    end
  end

  // Tags travel alongside the buffer read so returned data knows its source FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int i = 0; i < RDLAT; i++) tag_prt[i] <= '0;
    end else begin
      tag_vld[0] <= pop;
      tag_prt[0] <= po_prt;
      for (int i = 1; i < RDLAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_prt[i] <= tag_prt[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= ptr_next(wr_ptr);
      if (out_hs)  rd_ptr <= ptr_next(rd_ptr);
      if (fifo_wr && !out_hs)      occ <= occ + 1'b1;
      else if (out_hs && !fifo_wr) occ <= occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_prt[wr_ptr]  <= tag_prt[RDLAT-1];
      fifo_data[wr_ptr] <= po_dout;
    end
  end

endmodule
